// File: rtl/seq2sim_pkg.sv
// Shared constants and helpers for the serial-to-parallel collector.
// Optional feature macro: SEQ2SIM_FILL_FLAG_EN (fill flag in the top).
package seq2sim_pkg;

  localparam int DIR_FORWARD  = 1;
  localparam int DIR_BACKWARD = 0;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_to_sim_shift_reg_if.sv
// Control/data bundle of the serial-to-parallel collector.
// SEQ2SIM_FILL_FLAG_EN adds the out_full status bit.
interface seq_to_sim_shift_reg_if #(
  parameter int BIT_WIDTH = 2,
  parameter int SHIFT_LEN = 4
);
  logic                           in_ctr_Srst;
  logic                           in_ctr_en;
  logic                           in_ctr_sh_en;
  logic [BIT_WIDTH-1:0]           in;
  logic [BIT_WIDTH*SHIFT_LEN-1:0] out;
`ifdef SEQ2SIM_FILL_FLAG_EN
  logic                           out_full;
`endif

`ifdef SEQ2SIM_FILL_FLAG_EN
  modport master (output in_ctr_Srst, in_ctr_en, in_ctr_sh_en, in,
                  input out, out_full);
  modport slave  (input in_ctr_Srst, in_ctr_en, in_ctr_sh_en, in,
                  output out, out_full);
`else
  modport master (output in_ctr_Srst, in_ctr_en, in_ctr_sh_en, in,
                  input out);
  modport slave  (input in_ctr_Srst, in_ctr_en, in_ctr_sh_en, in,
                  output out);
`endif
endinterface

// File: rtl/seq2sim_delay_line.sv
// Input pipeline for the collector: DEPTH register stages, cleared by the
// async reset and by the synchronous clear. DEPTH=0 is a plain wire.
module seq2sim_delay_line #(
  parameter int DEPTH = 0,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst_n, srst};
      assign q = d;
    end else begin : g_regs
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Stage shift register; both clears wipe every stage.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stage_q <= '{default: '0};
        end else if (srst) begin
          stage_q <= '{default: '0};
        end else begin
          stage_q[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/seq_to_sim_shift_reg.sv
// Serial-to-parallel collector: keeps the last SHIFT_LEN words on out.
// SEQ2SIM_FILL_FLAG_EN adds a saturating fill counter driving out_full.
module seq_to_sim_shift_reg
  import seq2sim_pkg::*;
#(
  parameter int DIRECTION    = DIR_FORWARD,
  parameter int SHIFT_LEN    = 4,
  parameter int BIT_WIDTH    = 2,
  parameter int CLK_DISTANCE = 1
) (
  input logic                  clk,
  input logic                  in_ctr_Arst_n,
  seq_to_sim_shift_reg_if.slave bus
);

  localparam bit IS_FWD = (DIRECTION > DIR_BACKWARD);

  logic [BIT_WIDTH-1:0] e_in;
  logic                 e_en;
  logic                 e_sh;
  logic [BIT_WIDTH-1:0] slice_q [SHIFT_LEN];
  logic [BIT_WIDTH-1:0] slice_d [SHIFT_LEN];

  // Data and enables are delayed together; the sync clear bypasses the delay.
  seq2sim_delay_line #(
    .DEPTH (CLK_DISTANCE - 1),
    .WIDTH (BIT_WIDTH + 2)
  ) u_delay (
    .clk   (clk),
    .rst_n (in_ctr_Arst_n),
    .srst  (bus.in_ctr_Srst),
    .d     ({bus.in, bus.in_ctr_en, bus.in_ctr_sh_en}),
    .q     ({e_in, e_en, e_sh})
  );

  generate
    if (IS_FWD) begin : g_fwd
      // Forward: newest word enters slice 0, older words move up.
      always_comb begin
        slice_d = slice_q;
        if (e_en) begin
          if (e_sh) begin
            for (int k = 1; k < SHIFT_LEN; k++) slice_d[k] = slice_q[k-1];
          end
          slice_d[0] = e_in;
        end
      end
    end else begin : g_bwd
      // Backward: newest word enters the top slice, older words move down.
      always_comb begin
        slice_d = slice_q;
        if (e_en) begin
          if (e_sh) begin
            for (int k = 0; k < SHIFT_LEN - 1; k++) slice_d[k] = slice_q[k+1];
          end
          slice_d[SHIFT_LEN-1] = e_in;
        end
      end
    end
  endgenerate

  // Slice storage with async reset and synchronous clear.
  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      slice_q <= '{default: '0};
    end else if (bus.in_ctr_Srst) begin
      slice_q <= '{default: '0};
    end else begin
      slice_q <= slice_d;
    end
  end

  generate
    for (genvar k = 0; k < SHIFT_LEN; k++) begin : g_out
      assign bus.out[k*BIT_WIDTH +: BIT_WIDTH] = slice_q[k];
    end
  endgenerate

`ifdef SEQ2SIM_FILL_FLAG_EN
  localparam int CNT_W = clog2(SHIFT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SHIFT_LEN);

  logic [CNT_W-1:0] fill_q;
  logic [CNT_W-1:0] fill_d;
  logic             full_q;

  // Count effective shifts, saturating once every slice holds a word.
  always_comb begin
    fill_d = fill_q;
    if (e_en && e_sh && (fill_q != CNT_MAX)) fill_d = fill_q + 1'b1;
  end

  // Fill counter and registered full flag.
  always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
    if (!in_ctr_Arst_n) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else if (bus.in_ctr_Srst) begin
      fill_q <= '0;
      full_q <= 1'b0;
    end else begin
      fill_q <= fill_d;
      full_q <= (fill_d == CNT_MAX);
    end
  end

  assign bus.out_full = full_q;
`endif

endmodule

// File: tb/tb_seq_to_sim_shift_reg.sv
// Bench for seq_to_sim_shift_reg: forward, backward and delayed (CD=3)
// instances against an arithmetic reference model.
// SEQ2SIM_FILL_FLAG_EN enables the out_full checks.
module tb_seq_to_sim_shift_reg;

  typedef struct {
    logic [1:0] din;
    bit         en;
    bit         sh;
  } cmd_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [7:0] m_f, m_b, m_d;
  cmd_t       q_d[$];
  int         m_cnt;

  seq_to_sim_shift_reg_if #(.BIT_WIDTH(2), .SHIFT_LEN(4)) if_f ();
  seq_to_sim_shift_reg_if #(.BIT_WIDTH(2), .SHIFT_LEN(4)) if_b ();
  seq_to_sim_shift_reg_if #(.BIT_WIDTH(2), .SHIFT_LEN(4)) if_d ();

  seq_to_sim_shift_reg #(.DIRECTION(1), .SHIFT_LEN(4), .BIT_WIDTH(2), .CLK_DISTANCE(1))
    u_fwd (.clk(clk), .in_ctr_Arst_n(rst_n), .bus(if_f.slave));
  seq_to_sim_shift_reg #(.DIRECTION(0), .SHIFT_LEN(4), .BIT_WIDTH(2), .CLK_DISTANCE(1))
    u_bwd (.clk(clk), .in_ctr_Arst_n(rst_n), .bus(if_b.slave));
  seq_to_sim_shift_reg #(.DIRECTION(1), .SHIFT_LEN(4), .BIT_WIDTH(2), .CLK_DISTANCE(3))
    u_dly (.clk(clk), .in_ctr_Arst_n(rst_n), .bus(if_d.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register contents viewed as one 8-bit number: forward shifting multiplies
  // by 4 and adds the new word; backward divides by 4 and adds it at the top.
  function automatic logic [7:0] next_val(input logic [7:0] v, input bit fwd, input cmd_t c);
    logic [7:0] w;
    w = 8'(c.din);
    if (!c.en) return v;
    if (fwd) return c.sh ? ((v << 2) | w) : ((v & 8'hFC) | w);
    return c.sh ? ((v >> 2) | (w << 6)) : ((v & 8'h3F) | (w << 6));
  endfunction

  task automatic model_clear();
    cmd_t z;
    z.din = 2'd0; z.en = 1'b0; z.sh = 1'b0;
    m_f = 8'h00; m_b = 8'h00; m_d = 8'h00; m_cnt = 0;
    q_d.delete();
    q_d.push_back(z);
    q_d.push_back(z);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_fwd"}, if_f.out, m_f);
    check({tag, "_bwd"}, if_b.out, m_b);
    check({tag, "_dly"}, if_d.out, m_d);
`ifdef SEQ2SIM_FILL_FLAG_EN
    check({tag, "_full"}, 8'(if_f.out_full), 8'(m_cnt == 4));
`endif
  endtask

  task automatic step(input logic [1:0] d, input bit en, input bit sh, input bit srst);
    cmd_t c;
    cmd_t old;
    c.din = d; c.en = en; c.sh = sh;
    if_f.in = d; if_f.in_ctr_en = en; if_f.in_ctr_sh_en = sh; if_f.in_ctr_Srst = srst;
    if_b.in = d; if_b.in_ctr_en = en; if_b.in_ctr_sh_en = sh; if_b.in_ctr_Srst = srst;
    if_d.in = d; if_d.in_ctr_en = en; if_d.in_ctr_sh_en = sh; if_d.in_ctr_Srst = srst;
    @(posedge clk);
    if (srst) begin
      model_clear();
    end else begin
      m_f = next_val(m_f, 1'b1, c);
      m_b = next_val(m_b, 1'b0, c);
      old = q_d.pop_front();
      q_d.push_back(c);
      m_d = next_val(m_d, 1'b1, old);
      if (en && sh && m_cnt < 4) m_cnt++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [1:0] seq [4];
    total = 0;
    bad   = 0;
    seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0;
    rst_n = 1'b0;
    if_f.in = '0; if_f.in_ctr_en = 1'b0; if_f.in_ctr_sh_en = 1'b0; if_f.in_ctr_Srst = 1'b0;
    if_b.in = '0; if_b.in_ctr_en = 1'b0; if_b.in_ctr_sh_en = 1'b0; if_b.in_ctr_Srst = 1'b0;
    if_d.in = '0; if_d.in_ctr_en = 1'b0; if_d.in_ctr_sh_en = 1'b0; if_d.in_ctr_Srst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Known-answer shifts 1,2,3,0
    for (int i = 0; i < 4; i++) begin
      step(seq[i], 1'b1, 1'b1, 1'b0);
      check_all("shift");
    end
    check("ka_fwd", if_f.out, 8'h6C);
    check("ka_bwd", if_b.out, 8'h39);

    // Hold for three edges, then overwrite the newest slice
    for (int i = 0; i < 3; i++) begin
      step($urandom_range(3), 1'b0, $urandom_range(1), 1'b0);
      check_all("hold");
    end
    check("hold_fwd", if_f.out, 8'h6C);
    step(2'd2, 1'b1, 1'b0, 1'b0);
    check_all("ovw");
    check("ovw_fwd", if_f.out, 8'h6E);

    // Synchronous clear wins over enable
    step(2'd3, 1'b1, 1'b1, 1'b1);
    check_all("srst");
    check("srst_fwd", if_f.out, 8'h00);

    // Pipeline latency of the CD=3 instance
    step(2'd3, 1'b1, 1'b1, 1'b0);
    check("lat_e0_dly", if_d.out, 8'h00);
    check("lat_e0_fwd", if_f.out, 8'h03);
    step(2'd0, 1'b0, 1'b0, 1'b0);
    check("lat_e1_dly", if_d.out, 8'h00);
    step(2'd0, 1'b0, 1'b0, 1'b0);
    check("lat_e2_dly", if_d.out, 8'h03);
    check_all("lat");

    // Async reset pulse between edges, with words still in the pipeline
    step(2'd1, 1'b1, 1'b1, 1'b0);
    step(2'd2, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all("arst");
    check("arst_fwd", if_f.out, 8'h00);
    rst_n = 1'b1;
    #1;
    step(2'd1, 1'b1, 1'b1, 1'b0);
    check_all("post_arst");

`ifdef SEQ2SIM_FILL_FLAG_EN
    step(2'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(2'd1, 1'b1, 1'b1, 1'b0);
    check("fill3", 8'(if_f.out_full), 8'h00);
    step(2'd1, 1'b1, 1'b1, 1'b0);
    check("fill4", 8'(if_f.out_full), 8'h01);
    step(2'd1, 1'b1, 1'b1, 1'b1);
    check("fill_srst", 8'(if_f.out_full), 8'h00);
`endif

    // Randomized traffic with occasional synchronous clears
    for (int i = 0; i < 400; i++) begin
      step(2'($urandom_range(3)), ($urandom_range(3) != 0), ($urandom_range(1) == 1),
           ($urandom_range(19) == 0));
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
